// File: rtl/seq_shifter_pkg.sv
// seq_shifter_pkg: shared widths, op codes and FSM state encodings for the sequential shifter
package seq_shifter_pkg;
    localparam int WIDTH = 16;
    localparam int CNT_W = 4;
    typedef enum logic [1:0] {
        OP_ROL = 2'b00,
        OP_SLL = 2'b01,
        OP_SRA = 2'b10,
        OP_SRL = 2'b11
    } op_e;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;
endpackage

// File: rtl/seq_shifter_shift_stage.sv
// shift_stage: one combinational shift level (amt is 1, 2, 4 or 8) shared by all stages
module shift_stage
    import seq_shifter_pkg::*;
(
    input  logic [WIDTH-1:0] data,
    input  op_e              op,
    input  logic [CNT_W-1:0] amt,
    output logic [WIDTH-1:0] res
);
    logic [CNT_W:0]          rot_back;
    logic signed [WIDTH-1:0] sra;
    assign rot_back = (CNT_W+1)'(WIDTH) - {1'b0, amt};
    assign sra      = $signed(data) >>> amt;
    assign res = op == OP_ROL ? (data << amt) | (data >> rot_back)
               : op == OP_SLL ? data << amt
               : op == OP_SRA ? $unsigned(sra)
               : data >> amt;
endmodule

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle 16-bit shifter, one power-of-two level per clock; SEQ_SHIFTER_EARLY_DONE_EN skips trailing zero-count levels
module seq_shifter
    import seq_shifter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] In,
    input  logic [CNT_W-1:0] Cnt,
    input  logic [1:0]       Op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out
);
    state_e           state_q;
    op_e              op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       stage_q;
    logic [WIDTH-1:0] acc_q, acc_d, shifted;
    logic [WIDTH-1:0] out_q;
    logic             in_ready_q, out_valid_q;
    logic [CNT_W-1:0] amt, rest;
    logic             last;

    shift_stage u_stage (
        .data (acc_q),
        .op   (op_q),
        .amt  (amt),
        .res  (shifted)
    );

    // Current level's shift amount, next accumulator and whether this level finishes the op
    always_comb begin
        amt   = CNT_W'(1) << stage_q;
        acc_d = cnt_q[stage_q] ? shifted : acc_q;
        rest  = (cnt_q >> stage_q) >> 1;
`ifdef SEQ_SHIFTER_EARLY_DONE_EN
        last  = rest == '0;
`else
        last  = stage_q == 2'd3;
`endif
    end

    // FSM: capture in IDLE, one level per cycle in RUN, hold result in DONE until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_ROL;
            cnt_q       <= '0;
            stage_q     <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (in_valid) begin
                    acc_q      <= In;
                    cnt_q      <= Cnt;
                    op_q       <= op_e'(Op);
                    stage_q    <= '0;
                    in_ready_q <= 1'b0;
                    state_q    <= ST_RUN;
                end
                ST_RUN: begin
                    acc_q   <= acc_d;
                    stage_q <= stage_q + 2'd1;
                    if (last) begin
                        out_q       <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Out       = out_q;
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: directed vectors for seq_shifter, latency expectations follow SEQ_SHIFTER_EARLY_DONE_EN
module tb_seq_shifter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] In = '0;
    logic [3:0]  Cnt = '0;
    logic [1:0]  Op = '0;
    logic        in_ready, out_valid;
    logic [15:0] Out;
    int          vectors = 0;
    int          miscompares = 0;

`ifdef SEQ_SHIFTER_EARLY_DONE_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    seq_shifter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .In        (In),
        .Cnt       (Cnt),
        .Op        (Op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Out       (Out)
    );

    always #5 clk = ~clk;

    function automatic int lat(input int early_lat);
        return EARLY ? early_lat : 4;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] d, input logic [3:0] c, input logic [1:0] o);
        int k = 0;
        In = d;
        Cnt = c;
        Op = o;
        in_valid = 1'b1;
        while (!in_ready && k < 20) begin
            step();
            k++;
        end
        chk("accept_ready", 16'(in_ready), 16'h1);
        step();
        in_valid = 1'b0;
        In = ~d;
        Cnt = ~c;
        Op = ~o;
    endtask

    task automatic collect(input string tag, input logic [15:0] exp, input int l);
        int k = 0;
        while (!out_valid && k < 20) begin
            step();
            k++;
        end
        chk({tag, "_lat"}, 16'(k), 16'(l));
        chk(tag, Out, exp);
        chk({tag, "_busy"}, 16'(in_ready), 16'h0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_ovld_clr"}, 16'(out_valid), 16'h0);
        chk({tag, "_idle"}, 16'(in_ready), 16'h1);
    endtask

    initial begin
        int k;
        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready", 16'(in_ready), 16'h1);
        chk("rst_out_valid", 16'(out_valid), 16'h0);
        chk("rst_out", Out, 16'h0000);

        issue(16'h8001, 4'd1, 2'b00);  collect("rol_1", 16'h0003, lat(1));
        issue(16'h1234, 4'd4, 2'b01);  collect("sll_4", 16'h2340, lat(3));
        issue(16'h8000, 4'd15, 2'b11); collect("srl_15", 16'h0001, lat(4));
        issue(16'h8000, 4'd15, 2'b10); collect("sra_15", 16'hFFFF, lat(4));
        issue(16'h4000, 4'd2, 2'b10);  collect("sra_2", 16'h1000, lat(2));
        issue(16'h1234, 4'd8, 2'b00);  collect("rol_8", 16'h3412, lat(4));
        issue(16'h8001, 4'd15, 2'b00); collect("rol_15", 16'hC000, lat(4));
        issue(16'h8421, 4'd4, 2'b10);  collect("sra_4", 16'hF842, lat(3));
        issue(16'hBEEF, 4'd0, 2'b10);  collect("cnt0", 16'hBEEF, lat(1));
        issue(16'h0001, 4'd2, 2'b01);  collect("sll_2", 16'h0004, lat(2));

        issue(16'h8001, 4'd1, 2'b00);
        k = 0;
        while (!out_valid && k < 20) begin
            step();
            k++;
        end
        chk("bp_first_valid", 16'(out_valid), 16'h1);
        In = 16'h00F0;
        Cnt = 4'd4;
        Op = 2'b11;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_out", Out, 16'h0003);
            chk("bp_out_valid", 16'(out_valid), 16'h1);
            chk("bp_in_ready", 16'(in_ready), 16'h0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release_ovld", 16'(out_valid), 16'h0);
        chk("bp_release_ready", 16'(in_ready), 16'h1);
        step();
        in_valid = 1'b0;
        chk("bp_pending_taken", 16'(in_ready), 16'h0);
        collect("bp_pending", 16'h000F, lat(3));

        issue(16'h1234, 4'd8, 2'b00);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrun_rst_ovld", 16'(out_valid), 16'h0);
        chk("midrun_rst_ready", 16'(in_ready), 16'h1);
        chk("midrun_rst_out", Out, 16'h0000);
        step();
        step();
        step();
        chk("midrun_dropped", 16'(out_valid), 16'h0);
        issue(16'h8421, 4'd4, 2'b10);  collect("post_rst", 16'hF842, lat(3));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
